// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: write-back arbiter and in-order FIFO feeding the
// single write port of the 32x64 register file. Two FUs hand in results over
// valid/ready; one entry drains per cycle onto registered wr_enable/wr_data.
// Tag 31 (hardwired zero register) is accepted and silently dropped.
// Optional build macro: WB_BYPASS_EN -- when the FIFO is empty, the first
// accepted result goes straight to the write registers (1-edge latency).
module regfile_writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [4:0]                 a_tag,
  input  logic [63:0]                a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_tag,
  input  logic [63:0]                b_data,
  output logic [31:0]                wr_enable,
  output logic [63:0]                wr_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  tag;
    logic [63:0] data;
  } wb_entry_t;

  wb_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [31:0]       r_wr_en;
  logic [63:0]       r_wr_data;

  logic [CW-1:0]     w_free;
  logic              w_a_enq;
  logic              w_b_enq;
  logic              w_pop;
  logic              w_bypass;
  wb_entry_t         w_e0;
  wb_entry_t         w_e1;
  logic              w_e0_vld;
  logic              w_e1_vld;
  wb_entry_t         w_f0;
  logic              w_f0_vld;
  logic              w_f1_vld;
  logic [CW-1:0]     w_nfifo;
  wb_entry_t         w_head;

  // Readiness is credit-based on the pre-edge count only; a same-cycle pop is
  // deliberately not credited so ready never depends on the drain path.
  assign w_free  = CW'(DEPTH) - r_count;
  assign a_ready = (w_free >= CW'(1));
  assign b_ready = a_valid ? (w_free >= CW'(2)) : (w_free >= CW'(1));

  // Tag 31 handshakes complete but never produce an entry.
  assign w_a_enq = a_valid & a_ready & (a_tag != 5'd31);
  assign w_b_enq = b_valid & b_ready & (b_tag != 5'd31);
  assign w_pop   = (r_count != '0);

  // Accepted results in arrival order: A first, then B.
  assign w_e0_vld = w_a_enq | w_b_enq;
  assign w_e0     = w_a_enq ? wb_entry_t'{a_tag, a_data} : wb_entry_t'{b_tag, b_data};
  assign w_e1_vld = w_a_enq & w_b_enq;
  assign w_e1     = wb_entry_t'{b_tag, b_data};

`ifdef WB_BYPASS_EN
  // Empty FIFO: the oldest new result skips the queue entirely.
  assign w_bypass = (r_count == '0) & w_e0_vld;
`else
  assign w_bypass = 1'b0;
`endif

  // What actually lands in the FIFO after a possible bypass.
  assign w_f0_vld = w_bypass ? w_e1_vld : w_e0_vld;
  assign w_f0     = w_bypass ? w_e1 : w_e0;
  assign w_f1_vld = w_bypass ? 1'b0 : w_e1_vld;
  assign w_nfifo  = CW'(w_f0_vld) + CW'(w_f1_vld);
  assign w_head   = r_mem[r_head];

  // Storage has no reset: pointers/count define validity, so stale data is
  // unreachable after a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_f0_vld) r_mem[r_tail]           <= w_f0;
      if (w_f1_vld) r_mem[r_tail + AW'(1)]  <= w_e1;
    end
  end

  // Pointer/count bookkeeping and the registered write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wr_en   <= '0;
      r_wr_data <= '0;
    end else begin
      r_count <= r_count + w_nfifo - CW'(w_pop);
      r_tail  <= r_tail + AW'(w_nfifo);
      if (w_pop) begin
        r_head    <= r_head + AW'(1);
        r_wr_en   <= 32'(1) << w_head.tag;
        r_wr_data <= w_head.data;
      end else if (w_bypass) begin
        r_wr_en   <= 32'(1) << w_e0.tag;
        r_wr_data <= w_e0.data;
      end else begin
        r_wr_en   <= '0;
      end
    end
  end

  assign wr_enable = r_wr_en;
  assign wr_data   = r_wr_data;
  assign count     = r_count;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: the driver pushes expected
// writes as results are accepted; a monitor pops and compares on every write.
module tb_regfile_writeback_arbiter;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  tag;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_tag, b_tag;
  logic [63:0] a_data, b_data;
  logic [31:0] wr_enable;
  logic [63:0] wr_data;
  logic [2:0]  count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mcount   = 0;
  bit   saw_dm1_block = 1'b0;
  exp_t sb[$];

  regfile_writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_tag(a_tag), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_tag(b_tag), .b_data(b_data),
    .wr_enable(wr_enable), .wr_data(wr_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every nonzero write must match the oldest expected result.
  always @(negedge clk) begin
    if (reset === 1'b1 && wr_enable !== 32'h0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got wr_enable %h wr_data %h expected no write", wr_enable, wr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_enable", {32'h0, wr_enable}, {32'h0, 32'(1) << e.tag});
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  // One clock of stimulus: checks ready against the model count, records
  // expected writes, advances the model, then checks count after the edge.
  task automatic step(input logic av, input logic [4:0] at, input logic [63:0] ad,
                      input logic bv, input logic [4:0] bt, input logic [63:0] bd,
                      output logic acc_a, output logic acc_b);
    logic ea, eb;
    int   n;
    @(negedge clk);
    a_valid = av; a_tag = at; a_data = ad;
    b_valid = bv; b_tag = bt; b_data = bd;
    #1;
    ea = (mcount <= DEPTH - 1);
    eb = av ? (mcount <= DEPTH - 2) : (mcount <= DEPTH - 1);
    chk("a_ready", {63'h0, a_ready}, {63'h0, ea});
    chk("b_ready", {63'h0, b_ready}, {63'h0, eb});
    if (mcount == DEPTH - 1 && av && !eb) saw_dm1_block = 1'b1;
    acc_a = av & ea;
    acc_b = bv & eb;
    n = 0;
    if (acc_a && at != 5'd31) begin sb.push_back(exp_t'{at, ad}); n++; end
    if (acc_b && bt != 5'd31) begin sb.push_back(exp_t'{bt, bd}); n++; end
    if (BYP && mcount == 0 && n > 0) n--;
    mcount = mcount + n - ((mcount > 0) ? 1 : 0);
    @(posedge clk);
    #1;
    chk("count", {61'h0, count}, 64'(mcount));
  endtask

  task automatic idle(input int cycles);
    logic xa, xb;
    for (int i = 0; i < cycles; i++) step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, xa, xb);
  endtask

  initial begin
    logic xa, xb;
    logic [4:0] ta, tb_;
    int nt;
    reset = 1'b0;
    a_valid = 1'b0; a_tag = '0; a_data = '0;
    b_valid = 1'b0; b_tag = '0; b_data = '0;

    // Reset held for two edges, then released.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_wr_enable", {32'h0, wr_enable}, 64'h0);
    chk("rst_wr_data", wr_data, 64'h0);
    chk("rst_count", {61'h0, count}, 64'h0);
    chk("rst_a_ready", {63'h0, a_ready}, 64'h1);
    chk("rst_b_ready", {63'h0, b_ready}, 64'h1);

    // Single result: tag 5, data 0x1F.
    step(1'b1, 5'd5, 64'h1F, 1'b0, 5'd0, 64'h0, xa, xb);
    chk("single_edgeN", {32'h0, wr_enable}, BYP ? 64'h20 : 64'h0);
    idle(1);
    chk("single_edgeN1", {32'h0, wr_enable}, BYP ? 64'h0 : 64'h20);
    chk("single_data", wr_data, 64'h1F);
    idle(1);
    chk("single_edgeN2", {32'h0, wr_enable}, 64'h0);

    // Same-cycle A(1) and B(2): tag 1 then tag 2.
    step(1'b1, 5'd1, 64'hA, 1'b1, 5'd2, 64'hB, xa, xb);
    chk("pair_count", {61'h0, count}, BYP ? 64'd1 : 64'd2);
    idle(3);

    // Burst: both valid every cycle, distinct tags, hold until accepted.
    nt = 3;
    ta = 5'(nt); tb_ = 5'(nt + 1); nt += 2;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ta, {32'hA5A5_0000, 27'h0, ta}, 1'b1, tb_, {32'hB5B5_0000, 27'h0, tb_}, xa, xb);
      if (xa) begin ta = 5'(nt); nt++; end
      if (xb) begin tb_ = 5'(nt); nt++; end
    end
    chk("burst_dm1_b_blocked", {63'h0, saw_dm1_block}, 64'h1);
    idle(6);
    chk("burst_drained", 64'(sb.size()), 64'h0);

    // Both tag 31: accepted, no entries, no writes for 3 cycles.
    step(1'b1, 5'd31, 64'hDEAD, 1'b1, 5'd31, 64'hBEEF, xa, xb);
    chk("z31_a_acc", {63'h0, xa}, 64'h1);
    chk("z31_b_acc", {63'h0, xb}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      chk("z31_no_write", {32'h0, wr_enable}, 64'h0);
      idle(1);
    end

    // Fill to 3 then reset for one edge: everything buffered is dropped.
    while (mcount < 3) step(1'b1, 5'd20, 64'h2020, 1'b1, 5'd21, 64'h2121, xa, xb);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b0;
    sb.delete();
    mcount = 0;
    @(posedge clk);
    #1;
    chk("midrst_count", {61'h0, count}, 64'h0);
    chk("midrst_wr_enable", {32'h0, wr_enable}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(4);
    chk("midrst_no_stale", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
